event_stat_reporter: RTL and testbench
======================================

EVENT_STAT_REPORTER -- requirements
Module: event_stat_reporter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: output symbol width in bits.
REQ-002 SHALL have parameter NUM_CNT, default 4: number of event counters, range 1..16.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: counter width in bits, an integer multiple of WIDTH.
REQ-004 SHALL have port clk  input  1: clock, all logic on the rising edge.
REQ-005 SHALL have port arst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port event_in  input  NUM_CNT: per-counter increment strobe, one increment per cycle high.
REQ-007 SHALL have port start_harvest  input  1: single-cycle request to snapshot and report.
REQ-008 SHALL have port dout_ready  input  1: downstream accepts the current symbol.
REQ-009 SHALL have port dout_valid  output  1: dout holds a valid report symbol.
REQ-010 SHALL have port dout  output  WIDTH: report symbol.
REQ-011 SHALL have port reporting  output  1: high from snapshot until the last symbol is accepted.

Function
REQ-012 SHALL have states IDLE and SEND, plus HDR when the header feature is compiled in.
REQ-013 SHALL saturate each counter at all-ones and never wrap.
REQ-014 SHALL, in IDLE with start_harvest high, copy all counters into a snapshot register and clear the live counters on the same edge.
REQ-015 SHALL, when event_in[i] is high on the snapshot edge, exclude that event from the snapshot and load live counter i with 1.
REQ-016 SHALL move from IDLE to HDR (feature in) or SEND (feature out) on the snapshot edge, so reporting rises one cycle after start_harvest.
REQ-017 SHALL ignore start_harvest outside IDLE, with no snapshot, clear or restart.
REQ-018 SHALL emit the snapshot counter 0 first; within each counter, most-significant WIDTH slice first; NUM_CNT*CNT_WIDTH/WIDTH symbols in total.
REQ-019 SHALL hold dout_valid high in HDR and SEND, and keep dout stable while dout_valid is high and dout_ready is low.
REQ-020 SHALL advance the symbol index only on a cycle with dout_valid and dout_ready both high.
REQ-021 SHALL return to IDLE on the edge that accepts the last symbol, with reporting and dout_valid low from the next cycle.
REQ-022 SHALL keep the live counters counting throughout HDR and SEND.
REQ-023 SHALL drive dout to zero whenever dout_valid is low.

Reset
REQ-024 SHALL, on arst, clear state to IDLE, all counters, the snapshot and the symbol index to 0, and drive reporting=0, dout_valid=0, dout=0.
REQ-025 SHALL abandon any report in progress on arst, with no further symbols emitted after release.

Configuration
REQ-026 SHALL, with ESR_HEADER_EN defined, emit two header symbols in HDR before the data: 8'hA5, then NUM_CNT zero-extended to WIDTH, each under the same handshake.
REQ-027 SHALL, without ESR_HEADER_EN, omit the HDR state and the header logic so the first symbol is counter 0's MS slice.

Structure
REQ-028 SHALL take the state encoding and the header constant ESR_HDR_MAGIC=8'hA5 from shared package esr_pkg.
REQ-029 SHALL instantiate sub-module esr_sat_counter (saturating increment, synchronous clear-with-load) once per counter.

Verification
REQ-030 SHALL cover: 3 events on ch0 and 5 on ch2, start_harvest, dout_ready=1 -> 16 symbols 00,00,00,03,00×4,00,00,00,05,00×4; reporting high 16 cycles (18 with header).
REQ-031 SHALL cover: ch1 preloaded to 32'hFFFF_FFFE, 4 events -> reported value FF,FF,FF,FF.
REQ-032 SHALL cover: dout_ready toggling 1,0,0,1 during a report -> dout held constant while not ready, no symbol lost or duplicated.
REQ-033 SHALL cover: event_in[0] high on the snapshot cycle after 7 prior events -> reported 7, next report 1 (no further events).
REQ-034 SHALL cover: second start_harvest during SEND -> ignored; exactly one report; live counters not cleared.
REQ-035 SHALL cover: arst asserted after symbol 5 -> dout_valid and reporting 0 immediately; a new start_harvest after release gives a full report of post-reset counts.

Source files
------------

// File: rtl/esr_pkg.sv
// Shared state encoding and header constant for the event statistics reporter.
// The HDR state exists only when ESR_HEADER_EN is defined.
package esr_pkg;

    localparam logic [7:0] ESR_HDR_MAGIC = 8'hA5;

`ifdef ESR_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } esr_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd2
    } esr_state_e;
`endif

endpackage

// File: rtl/esr_sat_counter.sv
// Saturating event counter. A clear reloads the counter with 0 or 1 so that an
// event landing on the clear edge is kept rather than lost.
module esr_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 clr,
    input  logic                 load_one,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_WIDTH'(load_one);
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/event_stat_reporter.sv
// Snapshots NUM_CNT saturating event counters and streams them out as WIDTH-bit
// symbols, counter 0 and MS slice first. Optional header: define ESR_HEADER_EN.
module event_stat_reporter
    import esr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NUM_CNT-1:0] event_in,
    input  logic               start_harvest,
    input  logic               dout_ready,
    output logic               dout_valid,
    output logic [WIDTH-1:0]   dout,
    output logic               reporting,
    output logic [1:0]         state_dbg
);

    localparam int SPC   = CNT_WIDTH / WIDTH;
    localparam int NSYM  = NUM_CNT * SPC;
    localparam int TOT   = NUM_CNT * CNT_WIDTH;
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    // Handshake: a symbol transfers on a rising edge where dout_valid and
    // dout_ready are both high; dout is held steady until that edge.

    esr_state_e           state_q, state_d;
    logic [TOT-1:0]       snap_q, snap_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TOT-1:0]       live_flat;
    logic [CNT_WIDTH-1:0] cnt_w [NUM_CNT];
    logic                 take;
    logic                 valid_c;
    logic [WIDTH-1:0]     dout_c;
`ifdef ESR_HEADER_EN
    logic                 hdr_q, hdr_d;
`endif

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        esr_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk      (clk),
            .arst     (arst),
            .clr      (take),
            .load_one (event_in[i]),
            .inc      (event_in[i]),
            .cnt      (cnt_w[i])
        );
    end

    // Counter 0 sits in the top bits so the report is a plain left shift.
    always_comb begin
        live_flat = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            live_flat[(NUM_CNT-1-i)*CNT_WIDTH +: CNT_WIDTH] = cnt_w[i];
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        take    = 1'b0;
        valid_c = 1'b0;
        dout_c  = '0;
`ifdef ESR_HEADER_EN
        hdr_d   = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_harvest) begin
                    take   = 1'b1;
                    snap_d = live_flat;
                    idx_d  = '0;
`ifdef ESR_HEADER_EN
                    hdr_d   = 1'b0;
                    state_d = ST_HDR;
`else
                    state_d = ST_SEND;
`endif
                end
            end
`ifdef ESR_HEADER_EN
            ST_HDR: begin
                valid_c = 1'b1;
                dout_c  = hdr_q ? WIDTH'(NUM_CNT) : WIDTH'(ESR_HDR_MAGIC);
                if (dout_ready) begin
                    hdr_d = 1'b1;
                    if (hdr_q) begin
                        state_d = ST_SEND;
                    end
                end
            end
`endif
            ST_SEND: begin
                valid_c = 1'b1;
                dout_c  = snap_q[TOT-1 -: WIDTH];
                if (dout_ready) begin
                    snap_d = snap_q << WIDTH;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
`ifdef ESR_HEADER_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
`ifdef ESR_HEADER_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    assign dout_valid = valid_c;
    assign dout       = dout_c;
    assign reporting  = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_event_stat_reporter.sv
// Randomized and directed bench for event_stat_reporter, checked against a
// counter/queue model of the report stream.
module tb_event_stat_reporter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int CW  = 32;
    localparam int SPC = CW / W;

    logic         clk = 1'b0;
    logic         arst;
    logic [N-1:0] event_in;
    logic         start_harvest;
    logic         dout_ready;
    logic         dout_valid;
    logic [W-1:0] dout;
    logic         reporting;
    logic [1:0]   state_dbg;

    // Narrow instance: lets a counter reach saturation in a few hundred cycles.
    logic [1:0]   s_ev;
    logic         s_start;
    logic         s_ready;
    logic         s_valid;
    logic [3:0]   s_dout;
    logic         s_rep;
    logic [1:0]   s_dbg;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] live [N];
    logic [W-1:0]  exp_q [$];
    bit            m_busy;

    always #5 clk = ~clk;

    event_stat_reporter #(.WIDTH(W), .NUM_CNT(N), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .arst          (arst),
        .event_in      (event_in),
        .start_harvest (start_harvest),
        .dout_ready    (dout_ready),
        .dout_valid    (dout_valid),
        .dout          (dout),
        .reporting     (reporting),
        .state_dbg     (state_dbg)
    );

    event_stat_reporter #(.WIDTH(4), .NUM_CNT(2), .CNT_WIDTH(8)) dut_s (
        .clk           (clk),
        .arst          (arst),
        .event_in      (s_ev),
        .start_harvest (s_start),
        .dout_ready    (s_ready),
        .dout_valid    (s_valid),
        .dout          (s_dout),
        .reporting     (s_rep),
        .state_dbg     (s_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) live[i] = '0;
        exp_q.delete();
        m_busy = 1'b0;
    endtask

    task automatic model_count(input logic [N-1:0] ev);
        for (int i = 0; i < N; i++) begin
            if (ev[i] && live[i] != {CW{1'b1}}) live[i] = live[i] + 1;
        end
    endtask

    task automatic model_snapshot(input logic [N-1:0] ev);
`ifdef ESR_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(W'(N));
`endif
        for (int c = 0; c < N; c++) begin
            for (int s = SPC - 1; s >= 0; s--) begin
                exp_q.push_back(W'(live[c] >> (s * W)));
            end
        end
        for (int i = 0; i < N; i++) live[i] = ev[i] ? CW'(1) : CW'(0);
    endtask

    // One cycle: drive inputs at the falling edge, check outputs, advance the model.
    task automatic step(input logic [N-1:0] ev, input logic st, input logic rdy);
        bit was_busy;
        @(negedge clk);
        event_in      = ev;
        start_harvest = st;
        dout_ready    = rdy;
        chk("dout_valid", 32'(dout_valid), 32'(m_busy));
        chk("reporting", 32'(reporting), 32'(m_busy));
        if (m_busy) chk("dout", 32'(dout), 32'(exp_q[0]));
        else        chk("dout_idle", 32'(dout), 32'h0);
        was_busy = m_busy;
        if (!was_busy && st) begin
            model_snapshot(ev);
            m_busy = 1'b1;
        end else begin
            model_count(ev);
        end
        if (was_busy && rdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_busy = 1'b0;
        end
    endtask

    // mode 0: always ready, no events; 1: ready 1,0,0,1 with random events; 2: random.
    task automatic drain(input int mode);
        int n = 0;
        logic rdy;
        logic [N-1:0] ev;
        while (m_busy && n < 300) begin
            case (mode)
                0:       begin rdy = 1'b1; ev = '0; end
                1:       begin rdy = (n % 4 == 0) || (n % 4 == 3); ev = N'($urandom); end
                default: begin rdy = 1'($urandom_range(0, 1)); ev = N'($urandom); end
            endcase
            step(ev, 1'b0, rdy);
            n++;
        end
        chk("drain_bound", 32'(n < 300), 32'h1);
        step('0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s_exp [$];
        arst          = 1'b1;
        event_in      = '0;
        start_harvest = 1'b0;
        dout_ready    = 1'b0;
        s_ev          = '0;
        s_start       = 1'b0;
        s_ready       = 1'b0;
        model_reset();

        #12;
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_reporting", 32'(reporting), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        @(negedge clk);
        arst = 1'b0;

        // 3 events on ch0, 5 on ch2, then a fully-ready report.
        repeat (3) step(4'b0101, 1'b0, 1'b0);
        repeat (2) step(4'b0100, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1);
        drain(0);

        // Backpressure 1,0,0,1 with events arriving mid-report.
        step('0, 1'b1, 1'b0);
        drain(1);

        // Event on the snapshot cycle: report 7, then 1.
        repeat (7) step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1);
        drain(0);
        step('0, 1'b1, 1'b1);
        drain(0);

        // A second start during SEND is ignored and does not clear live counts.
        step('0, 1'b1, 1'b1);
        repeat (3) step(4'b1010, 1'b0, 1'b1);
        step(4'b1010, 1'b1, 1'b1);
        drain(0);
        step('0, 1'b1, 1'b1);
        drain(0);

        // Reset after symbol 5 abandons the report.
        repeat (4) step(4'b0110, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1);
        repeat (5) step(4'b0011, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        event_in      = '0;
        start_harvest = 1'b0;
        dout_ready    = 1'b0;
        arst          = 1'b1;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'h0);
        chk("arst_reporting", 32'(reporting), 32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        repeat (3) step('0, 1'b0, 1'b1);
        repeat (6) step(4'b1001, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1);
        drain(0);

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(5, 30);
            for (int k = 0; k < len; k++) step(N'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            step(N'($urandom), 1'b1, 1'($urandom_range(0, 1)));
            drain(2);
        end

        // Saturation on the narrow instance: 258 events on ch1 report as FF.
        repeat (258) begin
            @(negedge clk);
            s_ev = 2'b10;
        end
        @(negedge clk);
        s_ev    = 2'b00;
        s_start = 1'b1;
        s_ready = 1'b1;
`ifdef ESR_HEADER_EN
        s_exp.push_back(4'h5);
        s_exp.push_back(4'h2);
`endif
        s_exp.push_back(4'h0);
        s_exp.push_back(4'h0);
        s_exp.push_back(4'hF);
        s_exp.push_back(4'hF);
        @(negedge clk);
        s_start = 1'b0;
        while (s_exp.size() > 0) begin
            chk("sat_valid", 32'(s_valid), 32'h1);
            chk("sat_dout", 32'(s_dout), 32'(s_exp.pop_front()));
            @(negedge clk);
        end
        chk("sat_done_valid", 32'(s_valid), 32'h0);
        chk("sat_done_reporting", 32'(s_rep), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
